// File: rtl/sprite_coll_ram.sv
// Sprite-collision map (MAP_WORDS x 1 bit) with a summary flag. A single map port is shared
// between CPU read/clear and a small FIFO of pending collision sets; an init sweep clears the map.
module sprite_coll_ram #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAP_WORDS  = 1024
) (
  input  logic                         VCLKx4,
  input  logic                         RESETn,
  input  logic                         sprcoll,
  input  logic [$clog2(MAP_WORDS)-1:0] sprcoll_ad,
  input  logic                         cpu_sel_ram,
  input  logic                         cpu_sel_sum,
  input  logic                         cpu_rd,
  input  logic                         cpu_wr,
  input  logic [$clog2(MAP_WORDS)-1:0] cpu_ad,
  output logic [7:0]                   cpu_dout,
  output logic                         coll_sum,
  output logic                         coll_ovf,
  output logic                         busy
);

  localparam int unsigned AW = $clog2(MAP_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   sweep_ptr;
  logic            map_mem  [MAP_WORDS];
  logic [AW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   fifo_cnt;

  logic            cpu_map_acc, cpu_map_wr, cpu_rd_only, sum_clr;
  logic            fifo_full, pop, push, drop, fifo_hit;
  logic            map_we, map_wd;
  logic [AW-1:0]   map_wa;

  assign cpu_map_acc = cpu_sel_ram & (cpu_rd | cpu_wr);
  assign cpu_map_wr  = cpu_sel_ram & cpu_wr;
  assign cpu_rd_only = cpu_rd & ~cpu_wr;
  assign sum_clr     = cpu_sel_sum & cpu_wr;
  assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop         = (state == S_RUN) & ~cpu_map_acc & (fifo_cnt != '0);
  assign push        = sprcoll & (~fifo_full | pop);
  assign drop        = sprcoll & ~push;
  assign busy        = (state == S_INIT);

  // Read-side hit on any queued set, including one being accepted on this same edge.
  always_comb begin
    fifo_hit = push & (sprcoll_ad == cpu_ad);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < fifo_cnt) && (fifo_mem[rd_ptr + PW'(i)] == cpu_ad))
        fifo_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    map_we    = 1'b0;
    map_wa    = sweep_ptr;
    map_wd    = 1'b0;
    case (state)
      S_INIT: begin
        map_we = 1'b1;
        if (sweep_ptr == AW'(MAP_WORDS - 1))
          state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cpu_map_wr) begin
          map_we = 1'b1;
          map_wa = cpu_ad;
        end else if (pop) begin
          map_we = 1'b1;
          map_wa = fifo_mem[rd_ptr];
          map_wd = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge VCLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      state     <= S_INIT;
      sweep_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT)
        sweep_ptr <= sweep_ptr + AW'(1);
    end
  end

  always_ff @(posedge VCLKx4) begin
    if (map_we)
      map_mem[map_wa] <= map_wd;
  end

  always_ff @(posedge VCLKx4) begin
    if (push)
      fifo_mem[wr_ptr] <= sprcoll_ad;
  end

  always_ff @(posedge VCLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  // Set beats clear so a same-cycle event is never lost by a summary write.
  always_ff @(posedge VCLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      coll_sum <= 1'b0;
      coll_ovf <= 1'b0;
    end else begin
      if (sprcoll)
        coll_sum <= 1'b1;
      else if (sum_clr)
        coll_sum <= 1'b0;
      if (drop)
        coll_ovf <= 1'b1;
      else if (sum_clr)
        coll_ovf <= 1'b0;
    end
  end

  always_ff @(posedge VCLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      cpu_dout <= 8'hFF;
    end else if (cpu_rd_only && (cpu_sel_ram || cpu_sel_sum)) begin
      if (state == S_INIT)
        cpu_dout <= 8'hFF;
      else if (cpu_sel_ram)
        cpu_dout <= {7'h7F, map_mem[cpu_ad] | fifo_hit};
      else
        cpu_dout <= {6'h3F, coll_ovf, coll_sum};
    end
  end

endmodule

// File: tb/tb_sprite_coll_ram.sv
// Directed bench for sprite_coll_ram: init sweep, collision drain, CPU read/clear, FIFO overflow, reset.
module tb_sprite_coll_ram;

  logic       clk = 1'b0;
  logic       RESETn;
  logic       sprcoll;
  logic [9:0] sprcoll_ad;
  logic       cpu_sel_ram, cpu_sel_sum, cpu_rd, cpu_wr;
  logic [9:0] cpu_ad;
  logic [7:0] cpu_dout;
  logic       coll_sum, coll_ovf, busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [9:0] t4a [6];

  sprite_coll_ram #(.FIFO_DEPTH(4), .MAP_WORDS(1024)) dut (
    .VCLKx4     (clk),
    .RESETn     (RESETn),
    .sprcoll    (sprcoll),
    .sprcoll_ad (sprcoll_ad),
    .cpu_sel_ram(cpu_sel_ram),
    .cpu_sel_sum(cpu_sel_sum),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_ad     (cpu_ad),
    .cpu_dout   (cpu_dout),
    .coll_sum   (coll_sum),
    .coll_ovf   (coll_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    sprcoll     = 1'b0;
    cpu_sel_ram = 1'b0;
    cpu_sel_sum = 1'b0;
    cpu_rd      = 1'b0;
    cpu_wr      = 1'b0;
  endtask

  task automatic map_read(input logic [9:0] a, input logic [7:0] exp, input string tag);
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = a;
    tick();
    idle();
    check(tag, {24'd0, cpu_dout}, {24'd0, exp});
  endtask

  task automatic map_clear(input logic [9:0] a);
    cpu_sel_ram = 1'b1; cpu_wr = 1'b1; cpu_ad = a;
    tick();
    idle();
  endtask

  task automatic sum_read(input logic [7:0] exp, input string tag);
    cpu_sel_sum = 1'b1; cpu_rd = 1'b1;
    tick();
    idle();
    check(tag, {24'd0, cpu_dout}, {24'd0, exp});
  endtask

  task automatic sum_write();
    cpu_sel_sum = 1'b1; cpu_wr = 1'b1;
    tick();
    idle();
  endtask

  task automatic wait_init(input string tag);
    while (busy === 1'b1 && cyc < 1100) tick();
    check(tag, cyc, 1024);
  endtask

  initial begin
    t4a = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066};
    RESETn = 1'b0; sprcoll_ad = '0; cpu_ad = '0;
    idle();
    tick(); tick();
    check("rst_dout", {24'd0, cpu_dout}, 32'hFF);
    check("rst_sum",  {31'd0, coll_sum}, 0);
    check("rst_ovf",  {31'd0, coll_ovf}, 0);
    check("rst_busy", {31'd0, busy}, 1);

    // T1: init sweep; an INIT-time event is queued and drained after the sweep
    RESETn = 1'b1; cyc = 0;
    sprcoll = 1'b1; sprcoll_ad = 10'h155;
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h155;
    tick();
    idle();
    check("init_sum_set", {31'd0, coll_sum}, 1);
    check("init_read",    {24'd0, cpu_dout}, 32'hFF);
    sum_write();
    check("init_sum_clr", {31'd0, coll_sum}, 0);
    wait_init("init_len");
    tick(); tick();
    map_read(10'h000, 8'hFE, "t1_rd0");
    map_read(10'h201, 8'hFE, "t1_rd513");
    map_read(10'h3FF, 8'hFE, "t1_rd1023");
    map_read(10'h155, 8'hFF, "t1_init_evt");
    sum_read(8'hFC, "t1_sum");

    // T2: uncontended push then pop
    sprcoll = 1'b1; sprcoll_ad = 10'h2A5;
    tick();
    sprcoll = 1'b0;
    tick();
    map_read(10'h2A5, 8'hFF, "t2_rd");
    sum_read(8'hFD, "t2_sum");

    // T3: map clear and summary clear
    map_clear(10'h2A5);
    map_read(10'h2A5, 8'hFE, "t3_rd");
    sum_write();
    sum_read(8'hFC, "t3_sum");

    // T4: CPU holds the port, FIFO fills, last two events dropped
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h000;
    for (int i = 0; i < 8; i++) begin
      sprcoll = (i < 6);
      sprcoll_ad = (i < 6) ? t4a[i] : 10'h000;
      tick();
      check("t4_hold_rd", {24'd0, cpu_dout}, 32'hFE);
    end
    idle();
    check("t4_ovf", {31'd0, coll_ovf}, 1);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 6; i++)
      map_read(t4a[i], (i < 4) ? 8'hFF : 8'hFE, "t4_rd");
    sum_read(8'hFF, "t4_sum");

    // Push and pop at full in the same cycle is accepted
    sum_write();
    check("full_ovf_clr", {31'd0, coll_ovf}, 0);
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h000;
    for (int i = 0; i < 4; i++) begin
      sprcoll = 1'b1; sprcoll_ad = 10'h100 + 10'(i);
      tick();
    end
    idle();
    sprcoll = 1'b1; sprcoll_ad = 10'h104;
    tick();
    idle();
    check("full_pushpop_ovf", {31'd0, coll_ovf}, 0);
    tick(); tick(); tick(); tick(); tick();
    map_read(10'h104, 8'hFF, "full_rd_last");
    map_read(10'h100, 8'hFF, "full_rd_first");
    sum_read(8'hFD, "full_sum");

    // Summary write loses to a same-cycle collision
    cpu_sel_sum = 1'b1; cpu_wr = 1'b1; sprcoll = 1'b1; sprcoll_ad = 10'h088;
    tick();
    idle();
    check("sumclr_vs_coll", {31'd0, coll_sum}, 1);
    tick();

    // T5: same-cycle push and read hit through the FIFO
    sprcoll = 1'b1; sprcoll_ad = 10'h003;
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h003;
    tick();
    idle();
    check("t5_bypass", {24'd0, cpu_dout}, 32'hFF);
    tick();
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_ad = 10'h005;
    tick();
    idle();
    check("rdwr_hold", {24'd0, cpu_dout}, 32'hFF);
    map_clear(10'h003);
    map_read(10'h003, 8'hFE, "t5_clr_rd");

    // T6: reset mid-run with three events queued
    sum_write();
    cpu_sel_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h000;
    for (int i = 0; i < 3; i++) begin
      sprcoll = 1'b1; sprcoll_ad = 10'h1A0 + 10'(i);
      tick();
    end
    idle();
    check("t6_pre_sum", {31'd0, coll_sum}, 1);
    RESETn = 1'b0;
    #1;
    check("t6_sum",  {31'd0, coll_sum}, 0);
    check("t6_busy", {31'd0, busy}, 1);
    check("t6_dout", {24'd0, cpu_dout}, 32'hFF);
    tick();
    RESETn = 1'b1; cyc = 0;
    wait_init("t6_init_len");
    tick(); tick();
    map_read(10'h1A0, 8'hFE, "t6_lost");
    sum_read(8'hFC, "t6_sum_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
